vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for 640x480@60 VGA. Divides the system clock into a pixel strobe
//  and runs horizontal/vertical counters. Drives pixel coordinates x/y to every sprite/overlay
//  display stage (logo, game-over, ROM-indexed sprites) and drives hsync/vsync/video_on to the
//  RGB output mux. Sits directly upstream of all *_display blocks.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (>=1); 100 MHz -> 25 MHz pixel rate
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL = sum = 800, must be <= 1024)
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL = sum = 525, must be <= 1024)
// PORTS
//  clk          in   1   system clock, single clock domain
//  reset        in   1   asynchronous, active-high reset
//  x            out  10  current pixel column (h counter)
//  y            out  10  current pixel row (v counter)
//  p_tick       out  1   pixel strobe, one clk wide, every CLK_DIV clks
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  video_on     out  1   high when (x,y) lies in the visible area
//  frame_start  out  1   one-clk pulse when counters wrap to (0,0)
//  frame_cnt    out  8   frame counter (present only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
//  - Reset (async, takes effect without a clock edge): div_cnt=0, x=0, y=0, p_tick=0, hsync=1,
//    vsync=1, frame_start=0, frame_cnt=0; video_on=1 (follows counters at (0,0)).
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. p_tick is registered and goes high in the
//    cycle after div_cnt==CLK_DIV-1. First p_tick after reset release is on the CLK_DIV-th
//    rising edge. CLK_DIV=1: p_tick high on every clk after the first edge.
//  - Counters advance only on edges where p_tick==1. x: 0..H_TOTAL-1, wraps to 0.
//    On the x wrap, y increments. y: 0..V_TOTAL-1, wraps to 0 when x and y wrap together.
//  - hsync, vsync are registered from next-state counter values, so they stay aligned with x/y
//    (zero relative latency).
//  - hsync = 0 iff x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751).
//  - vsync = 0 iff y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491).
//  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY), combinational from the registered counters.
//  - frame_start is registered: high for exactly one clk, the cycle in which x/y first read (0,0)
//    after a wrap from (H_TOTAL-1, V_TOTAL-1). Not asserted on reset release.
//  - x/y hold their value between p_ticks. Downstream synchronous ROMs get CLK_DIV-1 spare clks
//    per pixel.
//  - Widths: counters are 10-bit unsigned. Compares are unsigned. No overflow past TOTAL-1.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined: frame_cnt port exists. It increments by 1 in the same cycle
//    frame_start is high and wraps 255->0. Used for sprite blink/animation.
//  VGA_FRAME_CNT_EN undefined: frame_cnt port and its register are absent. All other behaviour
//    is identical.
// TESTING
//  1. Hold reset 5 clks, CLK_DIV=4 -> x=0, y=0, hsync=vsync=1, p_tick=0. After release,
//     p_tick is high on the 4th edge and then every 4 clks.
//  2. Run one line -> x steps 0..799 then 0 and y increments. hsync low for exactly 96 p_ticks
//     starting at x=656.
//  3. Run one frame -> vsync low for y=490..491 (1600 p_ticks). y wraps 524->0. frame_start is
//     exactly one clk wide, once per 420000 p_ticks.
//  4. Count video_on p_ticks over one frame -> 307200. video_on=0 at (640,0) and at (0,480).
//  5. Assert reset asynchronously mid-frame at (300,200), between clk edges -> all outputs
//     return to reset values immediately. Restart matches scenario 1.
//  6. With VGA_FRAME_CNT_EN defined: run 257 frames -> frame_cnt 0..255, 0, 1.
//     Without the macro: elaboration shows no frame_cnt port.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-strobe divider plus horizontal/vertical counters,
// registered syncs and a frame-start pulse. Defining VGA_FRAME_CNT_EN adds the 8-bit
// frame_cnt output and its register.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       p_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             p_tick_q, p_tick_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             frame_start_q, frame_start_d;
   logic             x_last, y_last;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

   // Next-state: divider, raster counters and sync levels derived from the next counters
   always_comb begin
      div_cnt_d     = div_cnt_q + DIV_W'(1);
      p_tick_d      = 1'b0;
      x_d           = x_q;
      y_d           = y_q;
      x_last        = (x_q == 10'(H_TOTAL - 1));
      y_last        = (y_q == 10'(V_TOTAL - 1));
      frame_start_d = 1'b0;

      if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
         div_cnt_d = '0;
         p_tick_d  = 1'b1;
      end

      // Counters move only on edges where the strobe is already registered high
      if (p_tick_q) begin
         if (x_last) begin
            x_d = '0;
            if (y_last) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Syncs use next-state counters so they line up with x/y in the same cycle
      hsync_d = !((x_d >= 10'(HS_START)) && (x_d <= 10'(HS_END)));
      vsync_d = !((y_d >= 10'(VS_START)) && (y_d <= 10'(VS_END)));
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
   end

   // State registers, asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q     <= '0;
         p_tick_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q   <= '0;
`endif
      end else begin
         div_cnt_q     <= div_cnt_d;
         p_tick_q      <= p_tick_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q   <= frame_cnt_d;
`endif
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign p_tick      = p_tick_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign video_on    = (x_q < 10'(H_DISPLAY)) && (y_q < 10'(V_DISPLAY));
`ifdef VGA_FRAME_CNT_EN
   assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two small-raster instances (CLK_DIV=4 and
// CLK_DIV=1) are compared every cycle against an arithmetic model of the raster position
// derived from the number of clock edges since reset release.
module tb_vga_timing_gen;

   localparam int unsigned AD = 4, AHD = 16, AHF = 2, AHS = 3, AHB = 3;
   localparam int unsigned AVD = 6, AVF = 1, AVS = 2, AVB = 2;
   localparam int unsigned AHT = AHD + AHF + AHS + AHB;
   localparam int unsigned AVT = AVD + AVF + AVS + AVB;
   localparam int unsigned BD = 1, BHD = 4, BHF = 1, BHS = 1, BHB = 2;
   localparam int unsigned BVD = 3, BVF = 1, BVS = 1, BVB = 1;
   localparam int unsigned BHT = BHD + BHF + BHS + BHB;
   localparam int unsigned BVT = BVD + BVF + BVS + BVB;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       p_tick;
      logic       hsync;
      logic       vsync;
      logic       video_on;
      logic       frame_start;
      logic [7:0] frame_cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc;
   int total = 0;
   int bad = 0;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic a_p_tick, a_hsync, a_vsync, a_video_on, a_frame_start;
   logic b_p_tick, b_hsync, b_vsync, b_video_on, b_frame_start;
   logic [7:0] a_frame_cnt, b_frame_cnt;
   obs_t obs_a, obs_b;

   always #5 clk = ~clk;

   // Edges since reset release; cleared asynchronously like the DUT
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   vga_timing_gen #(
      .CLK_DIV(AD), .H_DISPLAY(AHD), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
      .V_DISPLAY(AVD), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB)
   ) u_dut_a (
      .clk(clk), .reset(reset), .x(a_x), .y(a_y), .p_tick(a_p_tick), .hsync(a_hsync),
      .vsync(a_vsync), .video_on(a_video_on), .frame_start(a_frame_start)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(a_frame_cnt)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV(BD), .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
   ) u_dut_b (
      .clk(clk), .reset(reset), .x(b_x), .y(b_y), .p_tick(b_p_tick), .hsync(b_hsync),
      .vsync(b_vsync), .video_on(b_video_on), .frame_start(b_frame_start)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(b_frame_cnt)
`endif
   );

`ifndef VGA_FRAME_CNT_EN
   assign a_frame_cnt = 8'd0;
   assign b_frame_cnt = 8'd0;
`endif

   assign obs_a = {a_x, a_y, a_p_tick, a_hsync, a_vsync, a_video_on, a_frame_start, a_frame_cnt};
   assign obs_b = {b_x, b_y, b_p_tick, b_hsync, b_vsync, b_video_on, b_frame_start, b_frame_cnt};

   // Expected outputs after c edges since reset release (c=0: in reset)
   function automatic obs_t model(input int unsigned c, input int unsigned d,
                                  input int unsigned hd, input int unsigned hf,
                                  input int unsigned hs, input int unsigned hb,
                                  input int unsigned vd, input int unsigned vf,
                                  input int unsigned vs, input int unsigned vb);
      obs_t e;
      int unsigned ht, vt, adv, pix, xi, yi;
      ht  = hd + hf + hs + hb;
      vt  = vd + vf + vs + vb;
      // Strobe is high after edges d, 2d, ...; pixels advance on the edge after each strobe
      adv = (c >= 1) ? (c - 1) / d : 0;
      pix = adv % (ht * vt);
      xi  = pix % ht;
      yi  = pix / ht;
      e.x           = 10'(xi);
      e.y           = 10'(yi);
      e.p_tick      = (c >= 1) && (c % d == 0);
      e.hsync       = !(xi >= hd + hf && xi < hd + hf + hs);
      e.vsync       = !(yi >= vd + vf && yi < vd + vf + vs);
      e.video_on    = (xi < hd) && (yi < vd);
      e.frame_start = (c >= 2) && ((c - 1) % d == 0) && (pix == 0);
`ifdef VGA_FRAME_CNT_EN
      e.frame_cnt   = 8'((adv / (ht * vt)) % 256);
`else
      e.frame_cnt   = 8'd0;
`endif
      return e;
   endfunction

   function automatic obs_t model_a(input int unsigned c);
      return model(c, AD, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB);
   endfunction

   function automatic obs_t model_b(input int unsigned c);
      return model(c, BD, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB);
   endfunction

   task automatic test_reset();
      obs_t rst_val;
      logic exp_tick;
      rst_val = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (obs_a !== rst_val) begin
            bad++;
            $display("FAIL reset_a: got %h want %h", obs_a, rst_val);
         end
         total++;
         if (obs_b !== rst_val) begin
            bad++;
            $display("FAIL reset_b: got %h want %h", obs_b, rst_val);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         exp_tick = (i % 4 == 0);
         total++;
         if (a_p_tick !== exp_tick) begin
            bad++;
            $display("FAIL ptick_a edge %0d: got %b want %b", i, a_p_tick, exp_tick);
         end
         total++;
         if (b_p_tick !== 1'b1) begin
            bad++;
            $display("FAIL ptick_b edge %0d: got %b want 1", i, b_p_tick);
         end
      end
   endtask

   task automatic test_line();
      int hs_ticks = 0;
      for (int i = 0; i < int'(AHT * AD); i++) begin
         @(negedge clk);
         if (a_p_tick && !a_hsync) hs_ticks++;
         total++;
         if (obs_a !== model_a(cyc)) begin
            bad++;
            $display("FAIL line_a c=%0d: got %h want %h", cyc, obs_a, model_a(cyc));
         end
      end
      total++;
      if (hs_ticks != int'(AHS)) begin
         bad++;
         $display("FAIL hsync_width: got %0d want %0d", hs_ticks, AHS);
      end
   endtask

   task automatic test_frame();
      int fs = 0, vs_ticks = 0, vid_ticks = 0;
      for (int i = 0; i < int'(AHT * AVT * AD); i++) begin
         @(negedge clk);
         if (a_frame_start) fs++;
         if (a_p_tick && !a_vsync) vs_ticks++;
         if (a_p_tick && a_video_on) vid_ticks++;
         total++;
         if (obs_a !== model_a(cyc)) begin
            bad++;
            $display("FAIL frame_a c=%0d: got %h want %h", cyc, obs_a, model_a(cyc));
         end
         total++;
         if (obs_b !== model_b(cyc)) begin
            bad++;
            $display("FAIL frame_b c=%0d: got %h want %h", cyc, obs_b, model_b(cyc));
         end
      end
      total++;
      if (fs != 1) begin
         bad++;
         $display("FAIL frame_start_count: got %0d want 1", fs);
      end
      total++;
      if (vs_ticks != int'(AVS * AHT)) begin
         bad++;
         $display("FAIL vsync_ticks: got %0d want %0d", vs_ticks, AVS * AHT);
      end
      total++;
      if (vid_ticks != int'(AHD * AVD)) begin
         bad++;
         $display("FAIL video_ticks: got %0d want %0d", vid_ticks, AHD * AVD);
      end
   endtask

   task automatic test_async_reset();
      obs_t rst_val, m;
      logic found = 1'b0;
      rst_val = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
      for (int i = 0; i < int'(AHT * AVT * AD + 8) && !found; i++) begin
         @(negedge clk);
         m = model_a(cyc);
         if (m.x == 10'd7 && m.y == 10'd3) found = 1'b1;
      end
      total++;
      if (!found || obs_a !== model_a(cyc)) begin
         bad++;
         $display("FAIL midframe_reach: got %h want %h", obs_a, model_a(cyc));
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (obs_a !== rst_val) begin
         bad++;
         $display("FAIL async_reset_a: got %h want %h", obs_a, rst_val);
      end
      total++;
      if (obs_b !== rst_val) begin
         bad++;
         $display("FAIL async_reset_b: got %h want %h", obs_b, rst_val);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (obs_a !== model_a(cyc)) begin
            bad++;
            $display("FAIL restart_a c=%0d: got %h want %h", cyc, obs_a, model_a(cyc));
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 6; it++) begin
         n = int'($urandom_range(20, 400));
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== model_a(cyc) || obs_b !== model_b(cyc)) begin
               bad++;
               $display("FAIL random c=%0d: a %h want %h, b %h want %h", cyc, obs_a,
                        model_a(cyc), obs_b, model_b(cyc));
            end
         end
         #($urandom_range(1, 4)) reset = 1'b1;
         #1;
         total++;
         if (obs_a !== model_a(0)) begin
            bad++;
            $display("FAIL random_reset: got %h want %h", obs_a, model_a(0));
         end
         @(negedge clk);
         reset = 1'b0;
      end
   endtask

`ifdef VGA_FRAME_CNT_EN
   task automatic test_frame_cnt();
      int fs = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < int'(257 * BHT * BVT * BD + 1); i++) begin
         @(negedge clk);
         if (b_frame_start) fs++;
         total++;
         if (obs_b !== model_b(cyc)) begin
            bad++;
            $display("FAIL fcnt_b c=%0d: got %h want %h", cyc, obs_b, model_b(cyc));
         end
      end
      total++;
      if (fs != 257 || b_frame_cnt !== 8'd1) begin
         bad++;
         $display("FAIL fcnt_wrap: frames %0d cnt %0d want 257 and 1", fs, b_frame_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_async_reset();
      test_random();
`ifdef VGA_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
